// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_core transmit signals shared by uart_tx_arbiter.
// slave is the arbiter side; master is the requester/uart_core side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_byte;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_byte;
  logic               tx_valid;
  logic               tx_done;

  modport slave (
    input  req_valid, req_byte, req_last, tx_done,
    output req_ready, tx_byte, tx_valid
  );

  modport master (
    output req_valid, req_byte, req_last, tx_done,
    input  req_ready, tx_byte, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the uart_core transmit channel.
// Optional idle-grant abort with timeout_err output: define UART_TXARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output logic [N_REQ-1:0]  gnt,
  output logic              busy,
  output logic              trunc_err
`ifdef UART_TXARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t           r_state, w_state_nx;
  logic [IW-1:0]    r_ptr, w_ptr_nx;
  logic [IW-1:0]    r_g, w_g_nx;
  logic [N_REQ-1:0] r_gnt, w_gnt_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_last, w_last_nx;
  logic [7:0]       r_tx_byte, w_tx_byte_nx;
  logic             r_tx_valid, w_tx_valid_nx;
  logic             r_trunc, w_trunc_nx;

  logic             w_pick_found;
  logic [IW-1:0]    w_pick;
  logic [IW:0]      w_sum;
  logic [IW-1:0]    w_g_inc;
  logic             w_g_valid;
  logic             w_g_last;
  logic [7:0]       w_g_byte;
  logic             w_forced;

`ifdef UART_TXARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    r_to_cnt, w_to_cnt_nx;
  logic             r_to_err, w_to_err_nx;
`endif

  // Rotating priority search; the sum stays below 2*N_REQ so one subtract wraps it.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick       = '0;
    w_sum        = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(N_REQ)) w_sum = w_sum - (IW+1)'(N_REQ);
      if (!w_pick_found && bus.req_valid[w_sum[IW-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick       = w_sum[IW-1:0];
      end
    end
  end

  assign w_g_inc   = (r_g == IW'(N_REQ - 1)) ? '0 : r_g + 1'b1;
  assign w_g_valid = bus.req_valid[r_g];
  assign w_g_last  = bus.req_last[r_g];
  assign w_g_byte  = bus.req_byte[{r_g, 3'b000} +: 8];
  assign w_forced  = (r_cnt == CW'(MAX_LEN - 1));

  always_comb begin
    w_state_nx    = r_state;
    w_ptr_nx      = r_ptr;
    w_g_nx        = r_g;
    w_gnt_nx      = r_gnt;
    w_cnt_nx      = r_cnt;
    w_last_nx     = r_last;
    w_tx_byte_nx  = r_tx_byte;
    w_tx_valid_nx = 1'b0;
    w_trunc_nx    = r_trunc;
    bus.req_ready = '0;
`ifdef UART_TXARB_TIMEOUT_EN
    w_to_cnt_nx   = r_to_cnt;
    w_to_err_nx   = r_to_err;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_gnt_nx         = '0;
          w_gnt_nx[w_pick] = 1'b1;
          w_g_nx           = w_pick;
          w_cnt_nx         = '0;
          w_state_nx       = SEND;
        end
      end
      SEND: begin
        bus.req_ready[r_g] = w_g_valid;
        if (w_g_valid) begin
          w_tx_byte_nx  = w_g_byte;
          w_tx_valid_nx = 1'b1;
          w_cnt_nx      = r_cnt + 1'b1;
          w_last_nx     = w_g_last | w_forced;
          if (w_forced && !w_g_last) w_trunc_nx = 1'b1;
          w_state_nx    = WAIT;
`ifdef UART_TXARB_TIMEOUT_EN
          w_to_cnt_nx   = '0;
        end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          w_gnt_nx      = '0;
          w_ptr_nx      = w_g_inc;
          w_to_cnt_nx   = '0;
          w_to_err_nx   = 1'b1;
          w_state_nx    = IDLE;
        end else begin
          w_to_cnt_nx   = r_to_cnt + 1'b1;
`endif
        end
      end
      WAIT: begin
        if (bus.tx_done) begin
          if (r_last) begin
            w_gnt_nx   = '0;
            w_ptr_nx   = w_g_inc;
            w_state_nx = IDLE;
          end else begin
            w_state_nx = SEND;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_g        <= '0;
      r_gnt      <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_tx_byte  <= '0;
      r_tx_valid <= 1'b0;
      r_trunc    <= 1'b0;
`ifdef UART_TXARB_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_to_err   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_ptr      <= w_ptr_nx;
      r_g        <= w_g_nx;
      r_gnt      <= w_gnt_nx;
      r_cnt      <= w_cnt_nx;
      r_last     <= w_last_nx;
      r_tx_byte  <= w_tx_byte_nx;
      r_tx_valid <= w_tx_valid_nx;
      r_trunc    <= w_trunc_nx;
`ifdef UART_TXARB_TIMEOUT_EN
      r_to_cnt   <= w_to_cnt_nx;
      r_to_err   <= w_to_err_nx;
`endif
    end
  end

  assign bus.tx_byte  = r_tx_byte;
  assign bus.tx_valid = r_tx_valid;
  assign gnt          = r_gnt;
  assign busy         = (r_state != IDLE);
  assign trunc_err    = r_trunc;
`ifdef UART_TXARB_TIMEOUT_EN
  assign timeout_err  = r_to_err;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a packet-level model.
// Build with UART_TXARB_TIMEOUT_EN to also exercise the idle-grant abort.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int ML = 8;
`ifdef UART_TXARB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  logic [N-1:0] gnt;
  logic         busy;
  logic         trunc_err;
`ifdef UART_TXARB_TIMEOUT_EN
  logic         timeout_err;
`endif

  uart_tx_arbiter #(.N_REQ(N), .MAX_LEN(ML), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .gnt(gnt),
    .busy(busy),
    .trunc_err(trunc_err)
`ifdef UART_TXARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Requester traffic: per-source FIFO of bytes with last flags.
  logic [7:0] qb[N][$];
  bit         ql[N][$];
  bit gaps = 0, spur = 0, gen_on = 0;
  int fixed_dly = 0;

  int         log_idx[$];
  logic [7:0] log_byte[$];

  // Packet-level model: who owns the channel, whether a byte is on the line.
  int         m_owner, m_cnt, m_ptr, m_idle;
  bit         m_out, m_just, m_last, m_trunc, m_tout;
  logic [7:0] m_byte;

  int u_cnt = 0;
  bit u_busy = 0;

  logic [N-1:0] s_valid, s_ready;
  bit           s_done, s_rst;
  logic [7:0]   s_hb[N];
  bit           s_hl[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_idle = 0;
    m_out = 0; m_just = 0; m_last = 0; m_trunc = 0; m_tout = 0; m_byte = 8'h00;
  endtask

  task automatic model_edge();
    if (s_rst) begin
      model_reset();
      return;
    end
    m_just = 0;
    if (m_owner < 0) begin
      if (s_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          if (s_valid[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_cnt = 0; m_out = 0; m_idle = 0;
      end
    end else if (!m_out) begin
      if (s_valid[m_owner]) begin
        m_byte = s_hb[m_owner];
        m_cnt++;
        m_last = s_hl[m_owner] || (m_cnt == ML);
        if (m_cnt == ML && !s_hl[m_owner]) m_trunc = 1;
        m_out = 1; m_just = 1; m_idle = 0;
      end else begin
`ifdef UART_TXARB_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          m_tout  = 1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_idle  = 0;
        end
`endif
      end
    end else if (s_done) begin
      if (m_last) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_out = 0;
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] eg, er;
    eg = '0; er = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (!m_out && bus.req_valid[m_owner]) er[m_owner] = 1'b1;
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_just));
    chk("tx_byte", 32'(bus.tx_byte), 32'(m_byte));
    chk("trunc_err", 32'(trunc_err), 32'(m_trunc));
`ifdef UART_TXARB_TIMEOUT_EN
    chk("timeout_err", 32'(timeout_err), 32'(m_tout));
`endif
  endtask

  task automatic push_pkt(input int i, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      qb[i].push_back(base + 8'(k));
      ql[i].push_back(k == len - 1);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    if (!s_rst)
      for (int i = 0; i < N; i++)
        if (s_ready[i] && s_valid[i]) begin
          void'(qb[i].pop_front());
          void'(ql[i].pop_front());
        end
    bus.tx_done = 1'b0;
    if (u_busy) begin
      u_cnt--;
      if (u_cnt <= 0) begin
        bus.tx_done = 1'b1;
        u_busy = 0;
      end
    end else if (spur && $urandom_range(0, 15) == 0) begin
      bus.tx_done = 1'b1;
    end
    if (gen_on)
      for (int i = 0; i < N; i++)
        if (qb[i].size() < 12 && $urandom_range(0, 19) == 0)
          push_pkt(i, int'($urandom_range(1, 10)), 8'($urandom));
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (qb[i].size() > 0) && !(gaps && $urandom_range(0, 3) == 0);
      bus.req_byte[8*i +: 8] = 8'h00;
      bus.req_last[i] = 1'b0;
      if (qb[i].size() > 0) begin
        bus.req_byte[8*i +: 8] = qb[i][0];
        bus.req_last[i] = ql[i][0];
      end
    end
    @(negedge clk);
    if (!rst) compare();
    if (bus.tx_valid && !rst) begin
      log_idx.push_back(onehot_idx(gnt));
      log_byte.push_back(bus.tx_byte);
      u_busy = 1;
      u_cnt = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 6));
    end
    s_valid = bus.req_valid;
    s_ready = bus.req_ready;
    s_done  = bus.tx_done;
    s_rst   = rst;
    for (int i = 0; i < N; i++) begin
      s_hb[i] = bus.req_byte[8*i +: 8];
      s_hl[i] = bus.req_last[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    log_idx.delete();
    log_byte.delete();
    step();
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_idx.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_log", 32'(log_idx.size()), 32'(n));
  endtask

  task automatic drain(input int budget);
    int  k = 0;
    bit  pend = 1;
    while (pend && k < budget) begin
      pend = (m_owner >= 0) || u_busy;
      for (int i = 0; i < N; i++) if (qb[i].size() > 0) pend = 1;
      if (pend) step();
      k++;
    end
    chk("drain", 32'(pend), 32'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_byte  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
    s_valid = '0; s_ready = '0; s_done = 0; s_rst = 1;
    for (int i = 0; i < N; i++) begin s_hb[i] = 8'h00; s_hl[i] = 0; end
    model_reset();

    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_txv", 32'(bus.tx_valid), 32'h0);
    chk("rst_txb", 32'(bus.tx_byte), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_trunc", 32'(trunc_err), 32'h0);

    // Single two-byte packet from requester 1, uart answers 10 cycles later.
    fixed_dly = 10;
    qb[1].push_back(8'hA5); ql[1].push_back(0);
    qb[1].push_back(8'h5A); ql[1].push_back(1);
    drain(200);
    chk("single_n", 32'(log_idx.size()), 32'd2);
    chk("single_i0", 32'(log_idx[0]), 32'd1);
    chk("single_b0", 32'(log_byte[0]), 32'hA5);
    chk("single_i1", 32'(log_idx[1]), 32'd1);
    chk("single_b1", 32'(log_byte[1]), 32'h5A);
    for (int i = 0; i < N; i++) push_pkt(i, 1, 8'(8'h10 + i));
    wait_log(3, 100);
    chk("ptr_after_single", 32'(log_idx[2]), 32'd2);
    drain(300);

    // Round-robin with all four continuously requesting.
    fixed_dly = 2;
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 1, 8'(8'h20 + i));
    wait_log(5, 200);
    chk("rr_0", 32'(log_idx[0]), 32'd0);
    chk("rr_1", 32'(log_idx[1]), 32'd1);
    chk("rr_2", 32'(log_idx[2]), 32'd2);
    chk("rr_3", 32'(log_idx[3]), 32'd3);
    chk("rr_4", 32'(log_idx[4]), 32'd0);
    drain(300);

    // Atomicity: requester 2 waits for requester 0's whole packet.
    do_reset();
    push_pkt(0, 3, 8'hC0);
    push_pkt(2, 1, 8'hD2);
    drain(200);
    chk("atom_n", 32'(log_idx.size()), 32'd4);
    chk("atom_i2", 32'(log_idx[2]), 32'd0);
    chk("atom_i3", 32'(log_idx[3]), 32'd2);
    chk("atom_b3", 32'(log_byte[3]), 32'hD2);

    // Truncation: 10-byte packet cut at 8, remainder after requesters 0 and 1.
    do_reset();
    push_pkt(3, 10, 8'h30);
    repeat (5) step();
    push_pkt(0, 1, 8'h40);
    push_pkt(1, 1, 8'h41);
    drain(400);
    chk("trunc_n", 32'(log_idx.size()), 32'd12);
    chk("trunc_i7", 32'(log_idx[7]), 32'd3);
    chk("trunc_i8", 32'(log_idx[8]), 32'd0);
    chk("trunc_i9", 32'(log_idx[9]), 32'd1);
    chk("trunc_i10", 32'(log_idx[10]), 32'd3);
    chk("trunc_b10", 32'(log_byte[10]), 32'h38);
    chk("trunc_err", 32'(trunc_err), 32'd1);

    // Reset in WAIT after byte 1 of 3; the in-flight tx_done lands in IDLE.
    do_reset();
    fixed_dly = 4;
    push_pkt(0, 3, 8'hE0);
    wait_log(1, 50);
    rst = 1'b1;
    qb[0].delete(); ql[0].delete();
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("rstmid_n", 32'(log_idx.size()), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_gnt", 32'(gnt), 32'd0);
    chk("rstmid_txb", 32'(bus.tx_byte), 32'd0);

    // Randomized traffic: gaps in valid, random uart latency, spurious tx_done.
    do_reset();
    fixed_dly = 0; gaps = 1; spur = 1; gen_on = 1;
    repeat (3000) step();
    gen_on = 0;
    drain(5000);
    gaps = 0; spur = 0;

`ifdef UART_TXARB_TIMEOUT_EN
    // Requester 1 stalls after its first byte; the grant is abandoned for 2.
    do_reset();
    fixed_dly = 3;
    qb[1].push_back(8'hA1); ql[1].push_back(0);
    push_pkt(2, 1, 8'hB2);
    wait_log(2, 200);
    chk("to_i0", 32'(log_idx[0]), 32'd1);
    chk("to_i1", 32'(log_idx[1]), 32'd2);
    chk("to_err", 32'(timeout_err), 32'd1);
    drain(200);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single transmit channel of uart_core among N_REQ packet sources, for example register-read responses, status/event reporters and debug echo.
- Arbitration is round-robin at packet granularity. Once a requester is granted, it owns the channel until its last byte has been transmitted.
- The block drives uart_core's tx_byte/tx_valid and paces itself on tx_done.
- It sits between uart_regs-style command handlers and uart_core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_LEN, 8, maximum bytes per packet. The packet is force-terminated at this count.
- TIMEOUT, 1023, idle-cycle limit used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: one clock clk; reset rst is synchronous and active-high.
- req_valid  input  N_REQ  per-requester byte valid.
- req_byte  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  N_REQ  marks the final byte of a packet.
- req_ready  output  N_REQ  byte accepted; combinational, at most one bit high.
- gnt  output  N_REQ  one-hot grant, registered.
- tx_byte  output  8  byte to uart_core.
- tx_valid  output  1  one-cycle start pulse to uart_core.
- tx_done  input  1  one-cycle pulse from uart_core when a byte has finished on the line.
- busy  output  1  high whenever state != IDLE.
- trunc_err  output  1  sticky; set when a packet is cut at MAX_LEN.

Behaviour:
- Reset values: state=IDLE, gnt=0, tx_valid=0, tx_byte=0, req_ready=0, busy=0, trunc_err=0, rr pointer ptr=0, byte_cnt=0.
- Reset overrides all other events. A uart_core byte already in flight completes on its own; its tx_done arrives in IDLE and is ignored.
- States are IDLE, SEND, WAIT.
- IDLE:
  - If any req_valid is high, pick the first set bit searching ptr, ptr+1, … mod N_REQ.
  - Set the one-hot gnt, set byte_cnt=0, go to SEND. There is no transmit in this cycle.
  - tx_done is ignored in IDLE.
- SEND:
  - req_ready[g] = req_valid[g] for the granted index g; all other bits stay 0.
  - On acceptance: tx_byte<=req_byte[g], tx_valid<=1 for exactly one cycle, byte_cnt<=byte_cnt+1, last_r<=req_last[g] | (byte_cnt==MAX_LEN-1); go to WAIT.
  - If req_valid[g] is low, stay in SEND holding gnt. Other requesters are never served mid-packet.
- WAIT:
  - tx_valid<=0 and req_ready=0.
  - On tx_done with last_r=1: set gnt=0, ptr<=(g+1) mod N_REQ, go to IDLE.
  - On tx_done with last_r=0: go to SEND.
- Truncation: if a byte is forced to last by MAX_LEN and req_last[g] was 0, trunc_err<=1. The requester's remaining bytes are then arbitrated as a new packet.
- Latency:
  - Packet start to first tx_valid is 2 cycles (IDLE→SEND, SEND asserts).
  - Between bytes of a packet: tx_done→SEND (1 cycle), then tx_valid on the next edge if data is ready.
- Spacing guarantee: tx_valid is never asserted while a byte is outstanding, i.e. from tx_valid until the matching tx_done.
- tx_done seen in SEND is ignored (spurious).
- Requests arriving while busy are held by their requesters (valid/ready); no request is lost.
- ptr advances only on packet completion. A requester with continuous traffic therefore cannot starve the others: worst-case wait is (N_REQ-1) packets.
- Pointer arithmetic wraps modulo N_REQ. With N_REQ not a power of two, an index of N_REQ-1 wraps to 0.

Optional Feature:
- Macro: UART_TXARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in SEND with req_valid[g]=0, and clears on acceptance.
  - When it reaches TIMEOUT, the grant is aborted: gnt=0, ptr<=g+1, state=IDLE.
  - Sticky output timeout_err (port exists only under the macro) is set to 1; reset clears it.
  - No byte is sent for the aborted remainder.
- Without the macro: the block waits indefinitely in SEND; no counter, no timeout_err port.

Test Plan:
- Single packet: req 1 sends bytes 0xA5, 0x5A (last on 0x5A); tx_done returned 10 cycles after each tx_valid.
  → Exactly two tx_valid pulses carrying 0xA5 then 0x5A; gnt=4'b0010 throughout; busy drops the cycle after the second tx_done; ptr=2.
- Round-robin: req_valid=4'b1111 in every cycle, each requester sending 1-byte packets, starting from ptr=0.
  → Grant order 0,1,2,3,0; one byte per grant.
- Packet atomicity: req 0 sends a 3-byte packet while req 2 is valid throughout.
  → All 3 bytes from req 0 go before any from req 2; req_ready[2] stays 0 until req 0's last tx_done.
- Truncation: MAX_LEN=8, req 3 sends 10 bytes with last only on byte 10.
  → 8 bytes are sent, then IDLE and trunc_err=1; the remaining 2 bytes go as a new packet after the other requesters' turns.
- Reset mid-packet: assert rst in WAIT after byte 1 of 3, then deliver a stale tx_done.
  → All outputs return to their reset values; the stale tx_done is ignored; no tx_valid until a new request arrives.
- Timeout (UART_TXARB_TIMEOUT_EN, TIMEOUT=20): req 1 sends byte 1 of 2 then drops valid.
  → After 20 idle cycles in SEND: gnt=0, timeout_err=1, and the next pending requester (2) is granted.
